// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, register-file write port,
// and a per-register pending-write scoreboard that decode queries for RAW hazards.
module wb_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 4,
  parameter int CNT_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      mem_wb_en_in,
  input  logic                      mem_r_en_in,
  input  logic [REG_FILE_DEPTH-1:0] dest_in,
  input  logic [WORD_WIDTH-1:0]     alu_result_in,
  input  logic [WORD_WIDTH-1:0]     mem_data_in,
  input  logic                      issue_valid,
  input  logic [REG_FILE_DEPTH-1:0] issue_dest,
  input  logic [REG_FILE_DEPTH-1:0] src1,
  input  logic [REG_FILE_DEPTH-1:0] src2,
  input  logic                      two_src,
  output logic                      WB_en,
  output logic [REG_FILE_DEPTH-1:0] WB_dest,
  output logic [WORD_WIDTH-1:0]     WB_result,
  output logic                      src1_busy,
  output logic                      src2_busy,
  output logic                      hazard,
  output logic                      sb_err
);

  localparam int NUM_REGS = 2 ** REG_FILE_DEPTH;

  logic                       wb_en_q;
  logic                       r_en_q;
  logic [REG_FILE_DEPTH-1:0]  dest_q;
  logic [WORD_WIDTH-1:0]      alu_q;
  logic [WORD_WIDTH-1:0]      mem_q;

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_d;
  logic [NUM_REGS-1:0]                inc;
  logic [NUM_REGS-1:0]                dec;
  logic [NUM_REGS-1:0]                busy;
  logic                               err_q;
  logic                               err_d;
  logic                               retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q <= 1'b0;
      r_en_q  <= 1'b0;
      dest_q  <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
    end else if (!freeze) begin
      wb_en_q <= mem_wb_en_in;
      r_en_q  <= mem_r_en_in;
      dest_q  <= dest_in;
      alu_q   <= alu_result_in;
      mem_q   <= mem_data_in;
    end
  end

  assign WB_en     = wb_en_q;
  assign WB_dest   = dest_q;
  assign WB_result = r_en_q ? mem_q : alu_q;

  // A frozen instruction stays on the write port but retires only once,
  // on the first edge where freeze is low.
  assign retire = wb_en_q & ~freeze;

  // issue_valid has no ready: decode raises it for exactly one cycle per
  // writing instruction leaving decode, and this stage always accepts it.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    inc   = '0;
    dec   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = issue_valid && (issue_dest == REG_FILE_DEPTH'(r));
      dec[r] = retire && (dest_q == REG_FILE_DEPTH'(r));
      if (inc[r] && !dec[r]) begin
        if (cnt_q[r] == '1) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      end else if (dec[r] && !inc[r]) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Busy comes from registered counts only; no bypass of a retiring write.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = |cnt_q[r];
  end

  assign src1_busy = busy[src1];
  assign src2_busy = busy[src2];
  assign hazard    = src1_busy | (two_src & src2_busy);
  assign sb_err    = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed and random stimulus for wb_stage, checked against a pending-count
// model of the register file writes kept in plain integers.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        mem_wb_en_in = 1'b0;
  logic        mem_r_en_in = 1'b0;
  logic [3:0]  dest_in = '0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] mem_data_in = '0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic [3:0]  src1 = '0;
  logic [3:0]  src2 = '0;
  logic        two_src = 1'b0;
  logic        WB_en;
  logic [3:0]  WB_dest;
  logic [31:0] WB_result;
  logic        src1_busy;
  logic        src2_busy;
  logic        hazard;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writes per register, the instruction sitting
  // at the write port, and the sticky error flag.
  int          pend[16];
  bit          m_en;
  logic [3:0]  m_dest;
  logic [31:0] m_res;
  bit          m_err;

  wb_stage #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .mem_wb_en_in(mem_wb_en_in), .mem_r_en_in(mem_r_en_in), .dest_in(dest_in),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .src1(src1), .src2(src2), .two_src(two_src),
    .WB_en(WB_en), .WB_dest(WB_dest), .WB_result(WB_result),
    .src1_busy(src1_busy), .src2_busy(src2_busy), .hazard(hazard), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    m_en = 0; m_dest = '0; m_res = '0; m_err = 0;
  endtask

  task automatic model_edge();
    bit ret;
    if (!rst) begin
      model_reset();
      return;
    end
    ret = m_en && !freeze;
    if (!(issue_valid && ret && issue_dest == m_dest)) begin
      if (issue_valid) begin
        if (pend[issue_dest] == 3) m_err = 1;
        else pend[issue_dest] = pend[issue_dest] + 1;
      end
      if (ret) begin
        if (pend[m_dest] == 0) m_err = 1;
        else pend[m_dest] = pend[m_dest] - 1;
      end
    end
    if (!freeze) begin
      m_en   = mem_wb_en_in;
      m_dest = dest_in;
      m_res  = mem_r_en_in ? mem_data_in : alu_result_in;
    end
  endtask

  task automatic check_all(input string tag);
    bit b1, b2;
    b1 = pend[src1] > 0;
    b2 = pend[src2] > 0;
    check({tag, ".WB_en"},     32'(WB_en),     32'(m_en));
    check({tag, ".WB_dest"},   32'(WB_dest),   32'(m_dest));
    check({tag, ".WB_result"}, WB_result,      m_res);
    check({tag, ".src1_busy"}, 32'(src1_busy), 32'(b1));
    check({tag, ".src2_busy"}, 32'(src2_busy), 32'(b2));
    check({tag, ".hazard"},    32'(hazard),    32'(b1 | (two_src & b2)));
    check({tag, ".sb_err"},    32'(sb_err),    32'(m_err));
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    freeze = 0; mem_wb_en_in = 0; mem_r_en_in = 0; dest_in = '0;
    alu_result_in = '0; mem_data_in = '0; issue_valid = 0; issue_dest = '0;
  endtask

  task automatic mem_write(input logic [3:0] d, input bit load,
                           input logic [31:0] alu, input logic [31:0] mem);
    mem_wb_en_in = 1; mem_r_en_in = load; dest_in = d;
    alu_result_in = alu; mem_data_in = mem;
  endtask

  initial begin
    model_reset();
    // Reset then idle
    #1;
    check_all("reset_async");
    step("reset_hold0");
    step("reset_hold1");
    rst = 1;
    for (int i = 0; i < 3; i++) step("idle");

    // ALU write-back to r5
    issue_valid = 1; issue_dest = 5; src1 = 5;
    step("alu_issue");
    issue_valid = 0;
    mem_write(5, 0, 32'h0000_00AA, 32'h0000_1234);
    step("alu_wb");
    check("alu_wb.const_result", WB_result, 32'h0000_00AA);
    check("alu_wb.const_dest", 32'(WB_dest), 32'd5);
    clear_inputs();
    step("alu_after");
    check("alu_after.const_en", 32'(WB_en), 32'd0);

    // Load plus freeze on r3
    issue_valid = 1; issue_dest = 3; src1 = 3;
    step("ld_issue");
    issue_valid = 0;
    mem_write(3, 1, 32'h5555_5555, 32'hDEAD_BEEF);
    step("ld_wb");
    clear_inputs();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step("ld_frozen");
      check("ld_frozen.const_result", WB_result, 32'hDEAD_BEEF);
      check("ld_frozen.const_busy", 32'(src1_busy), 32'd1);
    end
    freeze = 0;
    step("ld_release");
    check("ld_release.const_busy", 32'(src1_busy), 32'd0);

    // Hazard lifecycle on r7
    issue_valid = 1; issue_dest = 7; src1 = 7; two_src = 0;
    step("hz_issue");
    check("hz_issue.const_hazard", 32'(hazard), 32'd1);
    issue_valid = 0;
    mem_write(7, 0, 32'h77, 32'h0);
    step("hz_retire_cycle");
    clear_inputs();
    step("hz_after_retire");
    check("hz_after_retire.const_hazard", 32'(hazard), 32'd0);
    issue_valid = 1; issue_dest = 7; src1 = 0; src2 = 7; two_src = 0;
    step("hz_src2_one_src");
    check("hz_src2_one_src.const_hazard", 32'(hazard), 32'd0);
    issue_valid = 0; two_src = 1;
    #1;
    check_all("hz_src2_two_src");
    check("hz_src2_two_src.const_hazard", 32'(hazard), 32'd1);
    mem_write(7, 0, 32'h77, 32'h0);
    step("hz_cleanup_wb");
    clear_inputs(); two_src = 0;
    step("hz_cleanup_done");

    // Simultaneous issue and retire on r2
    issue_valid = 1; issue_dest = 2; src1 = 2;
    step("sim_issue");
    issue_valid = 0;
    mem_write(2, 0, 32'h22, 32'h0);
    step("sim_wb");
    clear_inputs();
    issue_valid = 1; issue_dest = 2;
    step("sim_both");
    check("sim_both.const_busy", 32'(src1_busy), 32'd1);
    check("sim_both.const_err", 32'(sb_err), 32'd0);
    issue_valid = 0;
    mem_write(2, 0, 32'h23, 32'h0);
    step("sim_wb2");
    clear_inputs();
    step("sim_done");
    check("sim_done.const_busy", 32'(src1_busy), 32'd0);

    // Saturation on r9
    src1 = 9;
    issue_valid = 1; issue_dest = 9;
    for (int i = 0; i < 4; i++) step("sat_issue");
    check("sat_issue.const_err", 32'(sb_err), 32'd1);
    issue_valid = 0;
    mem_write(9, 0, 32'h99, 32'h0);
    for (int i = 0; i < 3; i++) step("sat_retire");
    clear_inputs();
    step("sat_drained");
    check("sat_drained.const_busy", 32'(src1_busy), 32'd0);
    mem_write(9, 0, 32'h99, 32'h0);
    step("sat_extra_wb");
    clear_inputs();
    step("sat_underflow");
    check("sat_underflow.const_err", 32'(sb_err), 32'd1);

    // Reset mid-operation with a write pending at the port
    issue_valid = 1; issue_dest = 4;
    step("mid_issue");
    issue_valid = 0;
    mem_write(4, 1, 32'h1, 32'hCAFE_F00D);
    step("mid_wb");
    #2 rst = 0;
    model_reset();
    #1;
    check_all("mid_reset_async");
    check("mid_reset.const_en", 32'(WB_en), 32'd0);
    step("mid_reset_hold");
    clear_inputs();
    rst = 1;
    step("mid_reset_release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      freeze        = ($urandom_range(0, 3) == 0);
      mem_wb_en_in  = $urandom_range(0, 1);
      mem_r_en_in   = $urandom_range(0, 1);
      dest_in       = 4'($urandom_range(0, 15));
      alu_result_in = $urandom;
      mem_data_in   = $urandom;
      issue_valid   = $urandom_range(0, 1);
      issue_dest    = 4'($urandom_range(0, 15));
      src1          = 4'($urandom_range(0, 15));
      src2          = 4'($urandom_range(0, 15));
      two_src       = $urandom_range(0, 1);
      if (i == 200) begin
        rst = 0;
        #1;
        model_reset();
        check_all("rand_reset");
      end
      if (i == 202) rst = 1;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. It is the writer side of the register-file port that the decode stage reads.
- Holds the MEM/WB pipeline register and selects the ALU result or the load data.
- Drives the register file write port (WB_en, WB_dest, WB_result).
- Keeps a per-register pending-write scoreboard. Decode queries it for RAW hazards: entries are set when a writing instruction issues out of decode and cleared when its write-back retires.

Parameters:
WORD_WIDTH, 32, datapath width.
REG_FILE_DEPTH, 4, register index width (16 registers).
CNT_WIDTH, 2, per-register in-flight counter width (max 3 pending writes per register).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-low reset.
freeze  in  1  holds the MEM/WB register and suppresses retire.
mem_wb_en_in  in  1  MEM-stage instruction writes a register.
mem_r_en_in  in  1  MEM-stage instruction is a load.
dest_in  in  REG_FILE_DEPTH  destination register.
alu_result_in  in  WORD_WIDTH  ALU result.
mem_data_in  in  WORD_WIDTH  load data.
issue_valid  in  1  a WB-enabled instruction leaves decode this cycle.
issue_dest  in  REG_FILE_DEPTH  its destination register.
src1, src2  in  REG_FILE_DEPTH  decode source indices.
two_src  in  1  decode instruction uses src2.
WB_en  out  1  register file write enable.
WB_dest  out  REG_FILE_DEPTH  write address.
WB_result  out  WORD_WIDTH  write data.
src1_busy, src2_busy  out  1  pending write to that source register.
hazard  out  1  src1_busy | (two_src & src2_busy).
sb_err  out  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - MEM/WB register cleared: wb_en_q=0, r_en_q=0, dest_q=0, alu_q=0, mem_q=0.
  - All 16 counters set to 0; sb_err=0.
  - Outputs therefore: WB_en=0, WB_dest=0, WB_result=0, src*_busy=0, hazard=0.
- Pipeline register:
  - On a rising edge with freeze=0, all MEM inputs are captured. With freeze=1 the register holds.
  - Latency is 1 cycle from the MEM inputs to the write port.
- Write port (combinational from the register):
  - WB_en = wb_en_q; WB_dest = dest_q.
  - WB_result = r_en_q ? mem_q : alu_q.
- Retire:
  - retire = wb_en_q & ~freeze, i.e. one pulse per instruction even if it is held for several cycles.
- Scoreboard, per register r, on each rising edge:
  - inc = issue_valid & (issue_dest==r); dec = retire & (dest_q==r).
  - inc&dec: count unchanged.
  - inc only: count+1. If count==3, hold count and set sb_err.
  - dec only: count-1. If count==0, hold at 0 and set sb_err.
- Busy and hazard:
  - busy[r] = (count[r]!=0), combinational from registered counts only.
  - A retiring write still reports busy in its retire cycle; this is conservative and no bypass is applied.
  - src1_busy = busy[src1]; src2_busy = busy[src2].
  - hazard as defined in Ports.
- sb_err: cleared only by reset.
- Reset mid-operation: all in-flight state is discarded. No write-port pulse is generated after rst falls.
- issue_valid, freeze and the MEM inputs are independent. Issue is still counted while frozen.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release with all inputs 0 -> WB_en=0, WB_result=0, hazard=0, sb_err=0 on every cycle.
- ALU write-back: mem_wb_en_in=1, mem_r_en_in=0, dest_in=5, alu_result_in=0x0000_00AA, mem_data_in=0x1234 for 1 cycle -> next cycle WB_en=1, WB_dest=5, WB_result=0xAA; the cycle after, WB_en=0.
- Load select plus freeze: load to r3 with mem_data_in=0xDEADBEEF, then freeze=1 for 3 cycles -> WB_en=1, WB_dest=3, WB_result=0xDEADBEEF held for 4 cycles; counter decrements exactly once, on the first edge with freeze=0.
- Hazard lifecycle:
  - Issue dest=7, src1=7, two_src=0 -> hazard=1 from the next cycle.
  - Write-back of r7 retires -> hazard=0 the cycle after the retire edge.
  - src2=7 with two_src=0 -> hazard=0.
- Simultaneous issue and retire on r2, with count 1 -> count stays 1, src1_busy stays 1, sb_err=0.
- Saturation: 4 issues to r9 with no retire -> count=3, sb_err=1. Then 3 retires to r9 -> busy clears. A further retire to r9 -> count stays 0 and sb_err stays 1.
